// File: rtl/cpu_pkg.sv
// Shared datapath constants and register-index type for the ARM-style core.
// Used by the register file, the read-address muxes and the decoder.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 15;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam reg_idx_t REG_PC = 4'd15;
    localparam reg_idx_t REG_LR = 4'd14;

endpackage

// File: rtl/reg_file_3p_if.sv
// Register-file bus: two read ports, general write port, link-register port, PC+8 input.
// The datapath drives it through master; the register file receives it through slave.
interface reg_file_3p_if;
    import cpu_pkg::*;

    reg_idx_t    A1;
    reg_idx_t    A2;
    reg_idx_t    A3;
    word_t       WD3;
    logic        WE3;
    logic        WE_LR;
    word_t       LR_D;
    word_t       R15;
    word_t       RD1;
    word_t       RD2;
    logic [15:0] WR_COUNT;

    modport master (
        output A1, A2, A3, WD3, WE3, WE_LR, LR_D, R15,
        input  RD1, RD2, WR_COUNT
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, WE_LR, LR_D, R15,
        output RD1, RD2, WR_COUNT
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: index decode, R15 (PC+8) substitution and,
// when REGFILE_BYPASS_EN is defined, forwarding of the write committing this cycle.
module rf_read_port
    import cpu_pkg::*;
(
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
    input  reg_idx_t                            addr_i,
    input  word_t                               r15_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                                wr_en_i,
    input  reg_idx_t                            wr_idx_i,
    input  word_t                               wr_data_i,
    input  logic                                lr_en_i,
    input  word_t                               lr_data_i,
`endif
    output word_t                               rd_o
);

    always_comb begin
        // NOTE: rd_o is assigned on every path first so no latch is inferred.
        rd_o = r15_i;
        if (addr_i != REG_PC) begin
            rd_o = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
            // General port outranks the link port, matching the write priority.
            if (wr_en_i && (wr_idx_i == addr_i)) begin
                rd_o = wr_data_i;
            end else if (lr_en_i && (addr_i == REG_LR)) begin
                rd_o = lr_data_i;
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file_3p.sv
// Architectural register file R0..R14 with PC+8 on index 15, two read ports,
// a general write port and a link-register port. Optional forwarding: REGFILE_BYPASS_EN.
module reg_file_3p
    import cpu_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    reg_file_3p_if.slave  bus
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [15:0]                         count_q, count_d;

    logic        gen_ok;
    logic        lr_ok;
    logic [1:0]  n_writes;
    logic [16:0] count_sum;

    // Writes to index 15 are dropped; a general write to R14 suppresses the link write.
    assign gen_ok   = bus.WE3 && (bus.A3 != REG_PC);
    assign lr_ok    = bus.WE_LR && !(gen_ok && (bus.A3 == REG_LR));
    assign n_writes = {1'b0, gen_ok} + {1'b0, lr_ok};

    always_comb begin
        regs_d = regs_q;
        if (lr_ok) begin
            regs_d[REG_LR] = bus.LR_D;
        end
        if (gen_ok) begin
            regs_d[bus.A3] = bus.WD3;
        end
    end

    assign count_sum = {1'b0, count_q} + 17'(n_writes);
    assign count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the register array is reset too, so reads of R0..R14 are 0 after reset.
            regs_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking updates keep every read this cycle on the old contents.
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    assign bus.WR_COUNT = count_q;

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (!$isunknown({bus.WE3, bus.WE_LR}));
        end
    end

    rf_read_port u_rd1 (
        .regs_i    (regs_q),
        .addr_i    (bus.A1),
        .r15_i     (bus.R15),
`ifdef REGFILE_BYPASS_EN
        .wr_en_i   (gen_ok),
        .wr_idx_i  (bus.A3),
        .wr_data_i (bus.WD3),
        .lr_en_i   (lr_ok),
        .lr_data_i (bus.LR_D),
`endif
        .rd_o      (bus.RD1)
    );

    rf_read_port u_rd2 (
        .regs_i    (regs_q),
        .addr_i    (bus.A2),
        .r15_i     (bus.R15),
`ifdef REGFILE_BYPASS_EN
        .wr_en_i   (gen_ok),
        .wr_idx_i  (bus.A3),
        .wr_data_i (bus.WD3),
        .lr_en_i   (lr_ok),
        .lr_data_i (bus.LR_D),
`endif
        .rd_o      (bus.RD2)
    );

endmodule

// File: tb/tb_reg_file_3p.sv
// Directed bench for reg_file_3p: reset, writes, R15 handling, LR priority,
// dual commit, read-during-write and WR_COUNT saturation.
module tb_reg_file_3p;
    import cpu_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    reg_file_3p_if bus ();

    reg_file_3p dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_writes();
        bus.WE3   = 1'b0;
        bus.WE_LR = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        bus.A1    = 4'd3;
        bus.A2    = 4'd0;
        bus.A3    = 4'd0;
        bus.WD3   = '0;
        bus.WE3   = 1'b0;
        bus.WE_LR = 1'b0;
        bus.LR_D  = '0;
        bus.R15   = '0;
        #1;
        check("reset_rd1", bus.RD1, 32'h0);
        check("reset_cnt", 32'(bus.WR_COUNT), 32'd0);

        @(negedge CLK);
        RST_N   = 1'b1;
        bus.WE3 = 1'b1; bus.A3 = 4'd3; bus.WD3 = 32'h1234;
        @(negedge CLK);
        idle_writes();
        #1;
        check("pre_reset_rd1", bus.RD1, 32'h1234);
        check("pre_reset_cnt", 32'(bus.WR_COUNT), 32'd1);

        // Asynchronous reset in the middle of the low phase, no edge in between.
        #2 RST_N = 1'b0;
        #1;
        check("async_reset_rd1", bus.RD1, 32'h0);
        check("async_reset_cnt", 32'(bus.WR_COUNT), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        bus.WE3 = 1'b1; bus.A3 = 4'd5; bus.WD3 = 32'hDEADBEEF;
        @(negedge CLK);
        idle_writes();
        bus.A1 = 4'd5;
        #1;
        check("basic_rd1", bus.RD1, 32'hDEADBEEF);
        check("basic_cnt", 32'(bus.WR_COUNT), 32'd1);

        bus.R15 = 32'h00000108; bus.A2 = 4'd15;
        #1;
        check("r15_rd2", bus.RD2, 32'h00000108);
        bus.WE3 = 1'b1; bus.A3 = 4'd15; bus.WD3 = 32'h1;
        @(negedge CLK);
        idle_writes();
        #1;
        check("r15_write_dropped_cnt", 32'(bus.WR_COUNT), 32'd1);
        check("r15_still_pc", bus.RD2, 32'h00000108);
        bus.R15 = 32'h0000010C;
        #1;
        check("r15_tracks", bus.RD2, 32'h0000010C);

        bus.WE3 = 1'b1; bus.A3 = 4'd14; bus.WD3 = 32'hAAAA;
        bus.WE_LR = 1'b1; bus.LR_D = 32'h00000044;
        @(negedge CLK);
        idle_writes();
        bus.A1 = 4'd14;
        #1;
        check("lr_conflict_rd1", bus.RD1, 32'hAAAA);
        check("lr_conflict_cnt", 32'(bus.WR_COUNT), 32'd2);

        bus.WE_LR = 1'b1; bus.LR_D = 32'h44;
        @(negedge CLK);
        idle_writes();
        #1;
        check("lr_only_rd1", bus.RD1, 32'h44);
        check("lr_only_cnt", 32'(bus.WR_COUNT), 32'd3);

        bus.WE3 = 1'b1; bus.A3 = 4'd2; bus.WD3 = 32'd7;
        bus.WE_LR = 1'b1; bus.LR_D = 32'd9;
        @(negedge CLK);
        idle_writes();
        bus.A1 = 4'd2; bus.A2 = 4'd14;
        #1;
        check("dual_rd1", bus.RD1, 32'd7);
        check("dual_rd2", bus.RD2, 32'd9);
        check("dual_cnt", 32'(bus.WR_COUNT), 32'd5);

        bus.WE3 = 1'b1; bus.A3 = 4'd6; bus.WD3 = 32'h11;
        @(negedge CLK);
        bus.A1 = 4'd6; bus.WD3 = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_rd1", bus.RD1, 32'h55);
`else
        check("rdw_rd1", bus.RD1, 32'h11);
`endif
        @(negedge CLK);
        idle_writes();
        #1;
        check("rdw_after_rd1", bus.RD1, 32'h55);
        check("rdw_after_cnt", 32'(bus.WR_COUNT), 32'd7);

        bus.WE_LR = 1'b1; bus.LR_D = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_lr_rd2", bus.RD2, 32'h77);
`else
        check("rdw_lr_rd2", bus.RD2, 32'd9);
`endif
        bus.WE3 = 1'b1; bus.A3 = 4'd14; bus.WD3 = 32'h88;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_conflict_rd2", bus.RD2, 32'h88);
`else
        check("rdw_conflict_rd2", bus.RD2, 32'd9);
`endif
        @(negedge CLK);
        idle_writes();
        #1;
        check("conflict_commit_rd2", bus.RD2, 32'h88);
        check("conflict_commit_cnt", 32'(bus.WR_COUNT), 32'd8);

        // Dual writes step the count by 2: 8 + 2*32763 = 65534.
        bus.A3 = 4'd0; bus.WE3 = 1'b1; bus.WE_LR = 1'b1; bus.LR_D = 32'h1;
        for (int i = 0; i < 32763; i++) begin
            bus.WD3 = 32'(i);
            @(negedge CLK);
        end
        idle_writes();
        bus.A1 = 4'd0;
        #1;
        check("near_sat_cnt", 32'(bus.WR_COUNT), 32'd65534);
        check("loop_last_rd1", bus.RD1, 32'd32762);

        bus.WE3 = 1'b1; bus.A3 = 4'd1; bus.WD3 = 32'h3;
        @(negedge CLK);
        #1;
        check("sat_cnt", 32'(bus.WR_COUNT), 32'hFFFF);
        bus.WE_LR = 1'b1;
        @(negedge CLK);
        idle_writes();
        #1;
        check("sat_hold_cnt", 32'(bus.WR_COUNT), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
